seq_subtractor: RTL

SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

---
 rtl/seq_subtractor.sv | 70 +++++++
 1 files changed

// File: rtl/seq_subtractor.sv
// seq_subtractor: bit-serial LSB-first subtractor with an IDLE/SHIFT/DONE FSM; optional SEQ_SUB_OVF_EN adds a signed overflow output ovf
module seq_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
`ifdef SEQ_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             d, br_n, last;
  // one full-subtractor bit slice; diff doubles as the result shift register and borrow as the running borrow
  always_comb begin
    d    = sa[0] ^ sb[0] ^ borrow;
    br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    last = cnt == CW'(WIDTH - 1);
    busy = state != IDLE;
    done = state == DONE;
  end
  // FSM, operand shifters, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      state  <= SHIFT;
      sa     <= a;
      sb     <= b;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (state == SHIFT) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      cnt    <= cnt + 1'b1;
      diff   <= {d, diff[WIDTH-1:1]};
      borrow <= br_n;
      state  <= last ? DONE : SHIFT;
`ifdef SEQ_SUB_OVF_EN
      if (last) ovf <= (sa[0] != sb[0]) && (d != sa[0]);
`endif
    end else begin
      state <= IDLE;
    end
  end
endmodule
